// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR/flag inputs plus every load strobe and mux select.
// The control unit takes the master side; the datapath (or a bench) takes the slave side.
interface control_unit_if #(
  parameter int DATAWIDTH = 8,
  parameter int sel1_size = 3,
  parameter int sel2_size = 2
);
  logic [DATAWIDTH-1:0] instruction;
  logic                 zero_flag;
  logic                 ld_r0, ld_r1, ld_r2, ld_r3;
  logic                 ld_pc, inc_pc, ld_ir, ld_address_reg, ld_reg_y, ld_reg_z;
  logic [sel1_size-1:0] sel_bus1_mux;
  logic [sel2_size-1:0] sel_bus2_mux;
  logic                 write;
  logic                 halted;

  modport master (
    input  instruction, zero_flag,
    output ld_r0, ld_r1, ld_r2, ld_r3, ld_pc, inc_pc, ld_ir, ld_address_reg,
           ld_reg_y, ld_reg_z, sel_bus1_mux, sel_bus2_mux, write, halted
  );

  modport slave (
    output instruction, zero_flag,
    input  ld_r0, ld_r1, ld_r2, ld_r3, ld_pc, inc_pc, ld_ir, ld_address_reg,
           ld_reg_y, ld_reg_z, sel_bus1_mux, sel_bus2_mux, write, halted
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 8-bit teaching CPU: fetch, decode, execute of
// ALU/NOT/RD/WR/BR/BRZ with a sticky halt on unknown opcodes.
module control_unit #(
  parameter int DATAWIDTH   = 8,
  parameter int opcode_size = 4,
  parameter int sel1_size   = 3,
  parameter int sel2_size   = 2
) (
  input logic          clk,
  input logic          clr,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FET1 = 4'd1, S_FET2 = 4'd2, S_DEC = 4'd3,
    S_EX1  = 4'd4, S_RD1  = 4'd5, S_RD2  = 4'd6, S_WR1 = 4'd7,
    S_WR2  = 4'd8, S_BR1  = 4'd9, S_BR2  = 4'd10, S_HALT = 4'd11
  } state_t;

  localparam logic [opcode_size-1:0] OP_NOP = 'd0, OP_ADD = 'd1, OP_SUB = 'd2,
                                     OP_AND = 'd3, OP_NOT = 'd4, OP_RD  = 'd5,
                                     OP_WR  = 'd6, OP_BR  = 'd7, OP_BRZ = 'd8;

  localparam logic [sel1_size-1:0] SEL1_PC   = sel1_size'(4);
  localparam logic [sel2_size-1:0] SEL2_ALU  = sel2_size'(0);
  localparam logic [sel2_size-1:0] SEL2_BUS1 = sel2_size'(1);
  localparam logic [sel2_size-1:0] SEL2_MEM  = sel2_size'(2);

  state_t state, state_nxt;

  logic [opcode_size-1:0] opcode;
  logic [1:0]             src, dest;
  assign opcode = bus.instruction[DATAWIDTH-1 -: opcode_size];
  assign src    = bus.instruction[3:2];
  assign dest   = bus.instruction[1:0];

  // Async clear drops straight to S_IDLE, which kills every strobe combinationally.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: state_nxt = S_FET1;
      S_FET1: state_nxt = S_FET2;
      S_FET2: state_nxt = S_DEC;
      S_DEC: begin
        case (opcode)
          OP_NOP, OP_NOT:         state_nxt = S_FET1;
          OP_ADD, OP_SUB, OP_AND: state_nxt = S_EX1;
          OP_RD:                  state_nxt = S_RD1;
          OP_WR:                  state_nxt = S_WR1;
          OP_BR:                  state_nxt = S_BR1;
          OP_BRZ:                 state_nxt = bus.zero_flag ? S_BR1 : S_FET1;
          default:                state_nxt = S_HALT;
        endcase
      end
      S_EX1:  state_nxt = S_FET1;
      S_RD1:  state_nxt = S_RD2;
      S_RD2:  state_nxt = S_FET1;
      S_WR1:  state_nxt = S_WR2;
      S_WR2:  state_nxt = S_FET1;
      S_BR1:  state_nxt = S_BR2;
      S_BR2:  state_nxt = S_FET1;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  logic [3:0]           ld_r;
  logic                 ld_pc, inc_pc, ld_ir, ld_ar, ld_y, ld_z, wr, halt;
  logic [sel1_size-1:0] sel1;
  logic [sel2_size-1:0] sel2;

  always_comb begin
    ld_r = '0; ld_pc = 1'b0; inc_pc = 1'b0; ld_ir = 1'b0; ld_ar = 1'b0;
    ld_y = 1'b0; ld_z = 1'b0; wr = 1'b0; halt = 1'b0;
    sel1 = '0; sel2 = '0;
    case (state)
      S_FET1: begin sel1 = SEL1_PC; sel2 = SEL2_BUS1; ld_ar = 1'b1; end
      S_FET2: begin sel2 = SEL2_MEM; ld_ir = 1'b1; inc_pc = 1'b1; end
      S_DEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            sel1 = sel1_size'(src); sel2 = SEL2_BUS1; ld_y = 1'b1;
          end
          OP_NOT: begin
            sel1 = sel1_size'(src); sel2 = SEL2_ALU; ld_z = 1'b1; ld_r = 4'b0001 << dest;
          end
          OP_RD, OP_WR, OP_BR: begin
            sel1 = SEL1_PC; sel2 = SEL2_BUS1; ld_ar = 1'b1;
          end
          // Untaken BRZ still has to step PC past its operand byte.
          OP_BRZ: begin
            if (bus.zero_flag) begin
              sel1 = SEL1_PC; sel2 = SEL2_BUS1; ld_ar = 1'b1;
            end else begin
              inc_pc = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_EX1: begin
        sel1 = sel1_size'(dest); sel2 = SEL2_ALU; ld_z = 1'b1; ld_r = 4'b0001 << dest;
      end
      S_RD1, S_WR1: begin sel2 = SEL2_MEM; ld_ar = 1'b1; inc_pc = 1'b1; end
      S_RD2:  begin sel2 = SEL2_MEM; ld_r = 4'b0001 << dest; end
      S_WR2:  begin sel1 = sel1_size'(src); wr = 1'b1; end
      S_BR1:  begin sel2 = SEL2_MEM; ld_ar = 1'b1; end
      S_BR2:  begin sel2 = SEL2_MEM; ld_pc = 1'b1; end
      S_HALT: halt = 1'b1;
      default: ;
    endcase
  end

  assign bus.ld_r0          = ld_r[0];
  assign bus.ld_r1          = ld_r[1];
  assign bus.ld_r2          = ld_r[2];
  assign bus.ld_r3          = ld_r[3];
  assign bus.ld_pc          = ld_pc;
  assign bus.inc_pc         = inc_pc;
  assign bus.ld_ir          = ld_ir;
  assign bus.ld_address_reg = ld_ar;
  assign bus.ld_reg_y       = ld_y;
  assign bus.ld_reg_z       = ld_z;
  assign bus.sel_bus1_mux   = sel1;
  assign bus.sel_bus2_mux   = sel2;
  assign bus.write          = wr;
  assign bus.halted         = halt;

endmodule

// File: tb/tb_control_unit.sv
// Directed per-cycle vector bench for control_unit, plus hand sequences for halt and async clear.
module tb_control_unit;
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  control_unit_if #(.DATAWIDTH(8), .sel1_size(3), .sel2_size(2)) bus();

  control_unit #(.DATAWIDTH(8), .opcode_size(4), .sel1_size(3), .sel2_size(2)) dut (
    .clk(clk), .clr(clr), .bus(bus)
  );

  // Packed view: {ld_r3..ld_r0, ld_pc, inc_pc, ld_ir, ld_ar, ld_y, ld_z, sel1[2:0], sel2[1:0], write, halted}
  typedef struct {
    string      name;
    logic [7:0] instr;
    logic       zf;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [16:0] o(input logic [3:0] ldr, input logic pc, inc, ir, ar, y, z,
                                    input logic [2:0] s1, input logic [1:0] s2, input logic wr, h);
    return {ldr, pc, inc, ir, ar, y, z, s1, s2, wr, h};
  endfunction

  function automatic logic [16:0] cur();
    return {bus.ld_r3, bus.ld_r2, bus.ld_r1, bus.ld_r0, bus.ld_pc, bus.inc_pc, bus.ld_ir,
            bus.ld_address_reg, bus.ld_reg_y, bus.ld_reg_z, bus.sel_bus1_mux,
            bus.sel_bus2_mux, bus.write, bus.halted};
  endfunction

  logic [16:0] ZERO, FET1, FET2, ADRV, HALT;

  task automatic chk(input string n, input logic [16:0] exp);
    logic [16:0] act;
    logic [3:0]  ldr;
    act = cur();
    ldr = act[16:13];
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
    checks++;
    if ((ldr & (ldr - 4'd1)) != 4'd0 || (act[1] && ldr != 4'd0)) begin
      errors++;
      $display("FAIL %s exclusivity: ld_r=%b write=%b, required one-hot-or-zero and not with write",
               n, ldr, act[1]);
    end
  endtask

  task automatic add(input string n, input logic [7:0] i, input logic zf, input logic [16:0] e);
    vec_t v;
    v.name = n; v.instr = i; v.zf = zf; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic add_fetch(input string n, input logic [7:0] i, input logic zf);
    add({n, "_fet1"}, i, zf, FET1);
    add({n, "_fet2"}, i, zf, FET2);
  endtask

  initial begin
    ZERO = '0;
    FET1 = o(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0);
    FET2 = o(4'b0000, 0, 1, 1, 0, 0, 0, 3'd0, 2'd2, 0, 0);
    ADRV = FET1;
    HALT = o(4'b0000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1);

    add("idle", 8'h16, 1'b0, ZERO);
    // ADD src R1 dest R2
    add_fetch("add", 8'h16, 1'b0);
    add("add_dec", 8'h16, 1'b0, o(4'b0000, 0, 0, 0, 0, 1, 0, 3'd1, 2'd1, 0, 0));
    add("add_ex1", 8'h16, 1'b0, o(4'b0100, 0, 0, 0, 0, 0, 1, 3'd2, 2'd0, 0, 0));
    add_fetch("nop", 8'h00, 1'b1);
    add("nop_dec", 8'h00, 1'b1, ZERO);
    // NOT src R1 dest R3
    add_fetch("not", 8'h47, 1'b0);
    add("not_dec", 8'h47, 1'b0, o(4'b1000, 0, 0, 0, 0, 0, 1, 3'd1, 2'd0, 0, 0));
    add_fetch("brz_nt", 8'h80, 1'b0);
    add("brz_nt_dec", 8'h80, 1'b0, o(4'b0000, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0));
    add_fetch("brz_t", 8'h80, 1'b1);
    add("brz_t_dec", 8'h80, 1'b1, ADRV);
    add("brz_t_br1", 8'h80, 1'b1, o(4'b0000, 0, 0, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
    add("brz_t_br2", 8'h80, 1'b1, o(4'b0000, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
    // WR src R0 dest R3
    add_fetch("wr", 8'h63, 1'b0);
    add("wr_dec", 8'h63, 1'b0, ADRV);
    add("wr_wr1", 8'h63, 1'b0, o(4'b0000, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
    add("wr_wr2", 8'h63, 1'b0, o(4'b0000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 1, 0));
    // RD src R3 dest R1
    add_fetch("rd", 8'h5D, 1'b0);
    add("rd_dec", 8'h5D, 1'b0, ADRV);
    add("rd_rd1", 8'h5D, 1'b0, o(4'b0000, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
    add("rd_rd2", 8'h5D, 1'b0, o(4'b0010, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
    add_fetch("br", 8'h70, 1'b0);
    add("br_dec", 8'h70, 1'b0, ADRV);
    add("br_br1", 8'h70, 1'b0, o(4'b0000, 0, 0, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
    add("br_br2", 8'h70, 1'b0, o(4'b0000, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
    // SUB src R3 dest R2, AND src R2 dest R1
    add_fetch("sub", 8'h2E, 1'b0);
    add("sub_dec", 8'h2E, 1'b0, o(4'b0000, 0, 0, 0, 0, 1, 0, 3'd3, 2'd1, 0, 0));
    add("sub_ex1", 8'h2E, 1'b0, o(4'b0100, 0, 0, 0, 0, 0, 1, 3'd2, 2'd0, 0, 0));
    add_fetch("and", 8'h39, 1'b1);
    add("and_dec", 8'h39, 1'b1, o(4'b0000, 0, 0, 0, 0, 1, 0, 3'd2, 2'd1, 0, 0));
    add("and_ex1", 8'h39, 1'b1, o(4'b0010, 0, 0, 0, 0, 0, 1, 3'd1, 2'd0, 0, 0));
    add_fetch("hlt", 8'hF0, 1'b0);
    add("hlt_dec", 8'hF0, 1'b0, ZERO);
    add("hlt_halt", 8'hF0, 1'b0, HALT);

    bus.instruction = 8'h16;
    bus.zero_flag   = 1'b0;
    #2;
    chk("reset_hold", ZERO);
    @(posedge clk); #1;
    chk("reset_after_edge", ZERO);
    clr = 1'b1;

    foreach (tbl[k]) begin
      bus.instruction = tbl[k].instr;
      bus.zero_flag   = tbl[k].zf;
      @(negedge clk);
      chk(tbl[k].name, tbl[k].exp);
      @(posedge clk); #1;
    end

    // Halt is sticky regardless of instruction/flag activity.
    for (int c = 0; c < 20; c++) begin
      bus.instruction = 8'(c * 13);
      bus.zero_flag   = c[0];
      @(negedge clk);
      chk("halt_hold", HALT);
    end
    #2 clr = 1'b0;
    #1 chk("halt_async_clr", ZERO);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    bus.instruction = 8'h5D;
    @(negedge clk); chk("post_halt_fet1", FET1);
    @(posedge clk); #1;
    @(negedge clk); chk("abort_fet2", FET2);
    @(posedge clk); #1;
    @(negedge clk); chk("abort_dec", ADRV);
    @(posedge clk); #1;
    @(negedge clk); chk("abort_rd1", o(4'b0000, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
    // Clear lands mid-cycle in S_RD1; strobes must drop before the next edge.
    #1 clr = 1'b0;
    #1 chk("abort_async", ZERO);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("abort_refetch", FET1);
    bus.instruction = 8'h90;
    @(posedge clk); #1;
    @(negedge clk); chk("op9_fet2", FET2);
    @(posedge clk); #1;
    @(negedge clk); chk("op9_dec", ZERO);
    @(posedge clk); #1;
    @(negedge clk); chk("op9_halt", HALT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, giving the instruction word width.
REQ-002 The block SHALL have parameter opcode_size, default 4, giving the opcode field width, instruction[7:4].
REQ-003 The block SHALL have parameter sel1_size, default 3, giving the bus-1 mux select width.
REQ-004 The block SHALL have parameter sel2_size, default 2, giving the bus-2 mux select width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 The block SHALL have port clr, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port instruction, input, DATAWIDTH bits: the IR contents, laid out as opcode[7:4], src[3:2], dest[1:0].
REQ-008 The block SHALL have port zero_flag, input, 1 bit: the registered Z flag.
REQ-009 The block SHALL have ports ld_r0, ld_r1, ld_r2, ld_r3, ld_pc, inc_pc, ld_ir, ld_address_reg, ld_reg_y and ld_reg_z, each output, 1 bit: the datapath load and increment strobes.
REQ-010 The block SHALL have port sel_bus1_mux, output, sel1_size bits: 0-3 select R0-R3, 4 selects PC.
REQ-011 The block SHALL have port sel_bus2_mux, output, sel2_size bits: 0 selects ALU, 1 selects bus1, 2 selects mem_word.
REQ-012 The block SHALL have port write, output, 1 bit: memory write strobe.
REQ-013 The block SHALL have port halted, output, 1 bit: high while in S_HALT.

Function
REQ-014 The block SHALL be a 12-state FSM, 4-bit state register: S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1, S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT.
REQ-015 Outputs SHALL be combinational from state plus, in S_DEC/S_EX1/S_RD2/S_WR2 only, instruction and zero_flag; every output not listed for a state SHALL be 0.
REQ-016 S_IDLE SHALL drive all outputs 0 and go to S_FET1.
REQ-017 S_FET1 SHALL drive sel_bus1_mux=4, sel_bus2_mux=1, ld_address_reg=1 and go to S_FET2.
REQ-018 S_FET2 SHALL drive sel_bus2_mux=2, ld_ir=1, inc_pc=1 and go to S_DEC.
REQ-019 In S_DEC, NOP (0000) SHALL drive nothing and go to S_FET1.
REQ-020 In S_DEC, ADD/SUB/AND (0001/0010/0011) SHALL drive sel_bus1_mux=src, sel_bus2_mux=1, ld_reg_y=1 and go to S_EX1.
REQ-021 In S_DEC, NOT (0100) SHALL drive sel_bus1_mux=src, sel_bus2_mux=0, ld_reg_z=1, ld_r[dest]=1 and go to S_FET1.
REQ-022 In S_DEC, RD/WR/BR (0101/0110/0111) SHALL drive sel_bus1_mux=4, sel_bus2_mux=1, ld_address_reg=1 and go to S_RD1/S_WR1/S_BR1 respectively.
REQ-023 In S_DEC, BRZ (1000) with zero_flag=1 SHALL act as BR; with zero_flag=0 it SHALL drive inc_pc=1 only (skip operand byte) and go to S_FET1.
REQ-024 In S_DEC, opcodes 1001-1111 SHALL drive nothing and go to S_HALT.
REQ-025 S_EX1 SHALL drive sel_bus1_mux=dest, sel_bus2_mux=0, ld_reg_z=1, ld_r[dest]=1 and go to S_FET1.
REQ-026 S_RD1 and S_WR1 SHALL drive sel_bus2_mux=2, ld_address_reg=1, inc_pc=1 and go to S_RD2/S_WR2.
REQ-027 S_RD2 SHALL drive sel_bus2_mux=2, ld_r[dest]=1 and go to S_FET1.
REQ-028 S_WR2 SHALL drive sel_bus1_mux=src, write=1 and go to S_FET1.
REQ-029 S_BR1 SHALL drive sel_bus2_mux=2, ld_address_reg=1 and go to S_BR2.
REQ-030 S_BR2 SHALL drive sel_bus2_mux=2, ld_pc=1 and go to S_FET1.
REQ-031 S_HALT SHALL drive halted=1, all other outputs 0, and remain there until reset.
REQ-032 Exactly one ld_r* SHALL be high in any cycle that loads a register; write and any ld_r* SHALL never be high together.
REQ-033 Cycles per instruction SHALL be: NOP 3, NOT 3, ALU 4, RD/WR/BR 5, BRZ taken 5, BRZ not taken 3.
REQ-034 Unreachable state encodings SHALL go to S_IDLE on the next clock.

Reset
REQ-035 clr=0 SHALL force state to S_IDLE immediately, independent of clk, so all outputs including halted read 0 within the same cycle.
REQ-036 Assertion of clr mid-instruction, in any state, SHALL abandon the instruction with no further strobes; the first edge after clr releases SHALL enter S_FET1.

Verification
REQ-037 Release clr, observe 3 cycles -> S_IDLE outputs all 0, then S_FET1 with sel1=4/sel2=1/ld_address_reg=1, then S_FET2 with ld_ir=1/inc_pc=1/sel2=2.
REQ-038 instruction=0x16 (ADD src R1 dest R2) -> S_DEC: sel1=1, sel2=1, ld_reg_y=1; S_EX1: sel1=2, sel2=0, ld_r2=1, ld_reg_z=1; back at S_FET1 4 cycles after entering S_FET1.
REQ-039 instruction=0x80 (BRZ), zero_flag=0 -> S_DEC inc_pc=1 only, then S_FET1; zero_flag=1 -> S_BR2 ld_pc=1, sel2=2, 5 cycles total.
REQ-040 instruction=0x63 (WR src R0) -> S_WR1 inc_pc=1/ld_address_reg=1, S_WR2 write=1/sel1=0, no ld_r* in any cycle.
REQ-041 instruction=0xF0 -> S_HALT, halted=1 held 20 cycles with all strobes 0; pulse clr=0 -> halted=0 asynchronously, before the next clock edge.
REQ-042 Assert clr=0 between clock edges while in S_RD1 -> inc_pc and ld_address_reg fall within the same cycle; after release, S_FET1 is entered with no S_RD2 strobes seen.
